// File: rtl/ls_exec_unit_if.sv
// Issue-queue, data-memory, CDB, store-completion and flush signals of the
// load/store execution unit, bundled so the unit and its environment
// connect through a single port.
interface ls_exec_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Issue queue side
    logic              IssueQue_Ready;
    logic [DATA_W-1:0] IssueQue_Data;
    logic [ADDR_W-1:0] IssueQue_Address;
    logic [4:0]        IssueQue_Rd_Tag;
    logic              IssueQue_Opcode;
    logic              Issueblk_Issue;

    // Single-port data memory
    logic              Mem_Req;
    logic              Mem_We;
    logic [ADDR_W-1:0] Mem_Addr;
    logic [DATA_W-1:0] Mem_Wdata;
    logic [DATA_W-1:0] Mem_Rdata;
    logic              Mem_Ack;

    // Common data bus
    logic              CDB_Req;
    logic              CDB_Grant;
    logic [4:0]        CDB_Tag;
    logic [DATA_W-1:0] CDB_Data;

    // Reorder buffer / retire side
    logic              LS_Store_Done;
    logic [4:0]        LS_Store_Tag;
    logic              LS_Exception;
    logic              RB_Flush_Valid;

    // The execution unit
    modport master (
        input  IssueQue_Ready, IssueQue_Data, IssueQue_Address, IssueQue_Rd_Tag,
        input  IssueQue_Opcode, Mem_Rdata, Mem_Ack, CDB_Grant, RB_Flush_Valid,
        output Issueblk_Issue, Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
        output CDB_Req, CDB_Tag, CDB_Data, LS_Store_Done, LS_Store_Tag, LS_Exception
    );

    // Queue, memory, arbiter and ROB as seen from outside the unit
    modport slave (
        output IssueQue_Ready, IssueQue_Data, IssueQue_Address, IssueQue_Rd_Tag,
        output IssueQue_Opcode, Mem_Rdata, Mem_Ack, CDB_Grant, RB_Flush_Valid,
        input  Issueblk_Issue, Mem_Req, Mem_We, Mem_Addr, Mem_Wdata,
        input  CDB_Req, CDB_Tag, CDB_Data, LS_Store_Done, LS_Store_Tag, LS_Exception
    );
endinterface

// File: rtl/ls_exec_unit.sv
// Load/store execution unit: accepts one memory instruction at a time from
// the issue queue, performs a single-port memory access, broadcasts load
// results on the CDB and reports store completion to the ROB. Flushes from
// the retire bus cancel the in-flight instruction without aborting the bus.
//
// Optional feature: define LS_ALIGN_CHECK_EN to trap misaligned addresses at
// accept (LS_Exception pulse, no memory access). Without it the low address
// bits are simply dropped and LS_Exception is tied low.
module ls_exec_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic            Clk,
    input  logic            Rst_n,
    ls_exec_unit_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        CDB  = 2'd2
    } state_t;

    state_t            state_q, state_d;

    // Holding registers for the in-flight instruction
    logic              op_load_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [4:0]        tag_q;
    logic [DATA_W-1:0] result_q;
    logic              killed_q;

    // Registered completion outputs
    logic              store_done_q;
    logic [4:0]        store_tag_q;

    // Decoded strobes from the FSM
    logic              issue;
    logic              capture;
    logic              load_capture;
    logic              store_done_d;

    // Accept only from IDLE and never in a flush cycle
    assign issue = (state_q == IDLE) && bus.IssueQue_Ready && !bus.RB_Flush_Valid;

`ifdef LS_ALIGN_CHECK_EN
    logic exc_d;
    logic exc_q;
    logic misaligned;

    assign misaligned = (bus.IssueQue_Address[1:0] != 2'b00);
`endif

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: sequential state is updated with non-blocking assignments only,
        // so every register samples pre-edge values regardless of block order.
        if (!Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        // NOTE: every output of this block is defaulted first; any path that
        // skipped an assignment would otherwise infer a latch.
        state_d      = state_q;
        capture      = 1'b0;
        load_capture = 1'b0;
        store_done_d = 1'b0;
`ifdef LS_ALIGN_CHECK_EN
        exc_d        = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (issue) begin
`ifdef LS_ALIGN_CHECK_EN
                    if (misaligned) begin
                        exc_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                        state_d = MEM;
                    end
`else
                    capture = 1'b1;
                    state_d = MEM;
`endif
                end
            end
            MEM: begin
                // The bus transaction always completes; a flush only decides
                // whether its result is reported.
                if (bus.Mem_Ack) begin
                    if (killed_q || bus.RB_Flush_Valid) begin
                        state_d = IDLE;
                    end else if (op_load_q) begin
                        load_capture = 1'b1;
                        state_d      = CDB;
                    end else begin
                        store_done_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            CDB: begin
                // A grant coinciding with a flush lands here too: the result
                // is dropped either way.
                if (bus.RB_Flush_Valid || bus.CDB_Grant) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Instruction holding registers, load result and sticky kill flag
    always_ff @(posedge Clk or negedge Rst_n) begin
        // NOTE: these few holding registers are reset so that every output
        // driven from them reads 0 out of reset.
        if (!Rst_n) begin
            op_load_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tag_q     <= '0;
            result_q  <= '0;
            killed_q  <= 1'b0;
        end else begin
            if (capture) begin
                op_load_q <= bus.IssueQue_Opcode;
                addr_q    <= bus.IssueQue_Address;
                wdata_q   <= bus.IssueQue_Data;
                tag_q     <= bus.IssueQue_Rd_Tag;
            end
            if (load_capture) begin
                result_q <= bus.Mem_Rdata;
            end
            // Set by a flush during MEM, held until the access retires
            killed_q <= (state_q == MEM) && (state_d == MEM) &&
                        (killed_q || bus.RB_Flush_Valid);
        end
    end

    // One-cycle completion pulses and their tag
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            store_done_q <= 1'b0;
            store_tag_q  <= '0;
        end else begin
            store_done_q <= store_done_d;
            if (store_done_d) begin
                store_tag_q <= tag_q;
            end
`ifdef LS_ALIGN_CHECK_EN
            if (exc_d) begin
                store_tag_q <= bus.IssueQue_Rd_Tag;
            end
`endif
        end
    end

`ifdef LS_ALIGN_CHECK_EN
    // Misaligned-access exception pulse
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= exc_d;
        end
    end

    assign bus.LS_Exception = exc_q;
`else
    assign bus.LS_Exception = 1'b0;
`endif

    assign bus.Issueblk_Issue = issue;

    // Memory outputs decode straight from the state register, so an
    // asynchronous reset drops Mem_Req immediately.
    assign bus.Mem_Req   = (state_q == MEM);
    assign bus.Mem_We    = (state_q == MEM) && !op_load_q;
    assign bus.Mem_Addr  = addr_q & ~ADDR_W'(3);
    assign bus.Mem_Wdata = wdata_q;

    assign bus.CDB_Req   = (state_q == CDB);
    assign bus.CDB_Tag   = tag_q;
    assign bus.CDB_Data  = result_q;

    assign bus.LS_Store_Done = store_done_q;
    assign bus.LS_Store_Tag  = store_tag_q;

endmodule

// File: doc/ls_exec_unit.md
# ls_exec_unit

Load/store execution unit that sits on the issue side of the load/store issue queue. It accepts one ready memory instruction per handshake (address already computed, store data already resolved) and performs a single-port data-memory access. It broadcasts load results on the CDB through a request/grant arbiter and reports store completion to the reorder buffer. It also honours retire-bus flushes.

## Interface
Parameters:
- ADDR_W, 32, memory byte-address width
- DATA_W, 32, data width

Ports:
- Clk  in  1  rising-edge clock
- Rst_n  in  1  reset, asynchronous, active-low
- IssueQue_Ready  in  1  queue head-of-ready entry valid
- IssueQue_Data  in  DATA_W  store data (ignored for loads)
- IssueQue_Address  in  ADDR_W  effective address
- IssueQue_Rd_Tag  in  5  destination/ROB tag
- IssueQue_Opcode  in  1  1 = load, 0 = store
- Issueblk_Issue  out  1  combinational accept strobe to queue
- Mem_Req  out  1  memory request
- Mem_We  out  1  1 = write
- Mem_Addr  out  ADDR_W  word address (bits [1:0] = 0)
- Mem_Wdata  out  DATA_W  write data
- Mem_Rdata  in  DATA_W  read data, valid with Mem_Ack
- Mem_Ack  in  1  transaction complete
- CDB_Req  out  1  request CDB slot
- CDB_Grant  in  1  arbiter grant, sampled while CDB_Req = 1
- CDB_Tag  out  5  load result tag
- CDB_Data  out  DATA_W  load result data
- LS_Store_Done  out  1  one-cycle store completion pulse
- LS_Store_Tag  out  5  tag for LS_Store_Done
- LS_Exception  out  1  misaligned-access pulse (see Configuration)
- RB_Flush_Valid  in  1  flush all speculative work

## Operation
- States: IDLE, MEM, CDB.
- IDLE: Issueblk_Issue = IssueQue_Ready & ~RB_Flush_Valid. On accept, register opcode, address, data and tag, then go to MEM.
- MEM: Mem_Req = 1. Mem_We = ~opcode. Address, write data and We stay stable until Mem_Ack.
  - Ack on a store: LS_Store_Done/LS_Store_Tag pulse the next cycle; go to IDLE.
  - Ack on a load: capture Mem_Rdata into the result register; go to CDB.
- CDB: CDB_Req = 1 with CDB_Tag/CDB_Data from the result register. On CDB_Grant, go to IDLE.
- Flush in IDLE: no accept that cycle.
- Flush in MEM: the bus transaction is never aborted. Mem_Req stays high until Mem_Ack. A sticky killed flag is set; on ack, no CDB request and no store-done pulse are produced, and the unit returns to IDLE.
- Flush in CDB: CDB_Req drops next cycle; go to IDLE; the result is discarded. A grant in the same cycle as the flush is ignored.
- Reset values: state IDLE; all outputs 0; the killed flag and all holding registers are 0.
- Only one instruction is in flight at a time. Issueblk_Issue is 0 in MEM and CDB.

## Timing
- Issueblk_Issue is combinational from IssueQue_Ready, state and RB_Flush_Valid, with no registered delay.
- Accept at edge T:
  - Mem_Req is high from cycle T+1.
  - Minimum store latency: ack in T+1 gives LS_Store_Done in T+2.
  - Minimum load latency: ack in T+1 gives CDB_Req in T+2; grant in T+2 returns to IDLE, so the next accept is possible in T+3.
- Mem_Ack is honoured only while Mem_Req = 1; a stray ack is ignored.
- LS_Store_Done and LS_Exception are exactly one cycle wide.
- Asserting Rst_n low mid-transaction returns to IDLE immediately and deasserts Mem_Req asynchronously. The memory side must tolerate an abandoned request.

## Configuration
- LS_ALIGN_CHECK_EN defined:
  - At accept, if IssueQue_Address[1:0] != 0, no memory access is made.
  - LS_Exception pulses in the next cycle, with LS_Store_Tag carrying the tag, and the unit stays in IDLE.
  - Under flush, the check is suppressed.
- LS_ALIGN_CHECK_EN undefined:
  - LS_Exception is tied 0.
  - Mem_Addr[1:0] is forced to 0 and the access proceeds normally.

## Test plan
- Store: Address 0x100, Data 0xDEADBEEF, tag 3, Opcode 0, ack after 2 cycles -> Mem_We = 1, Mem_Addr 0x100, Mem_Wdata 0xDEADBEEF; LS_Store_Done pulse with tag 3; no CDB_Req.
- Load: Address 0x104, tag 7, Rdata 0x12345678, ack same cycle as Mem_Req, grant delayed 3 cycles -> CDB_Req held 4 cycles with tag 7 and data 0x12345678; then IDLE; Issueblk_Issue is 0 throughout.
- Back-to-back loads, zero wait and immediate grant -> accepts are 3 cycles apart.
- Flush during MEM (load, ack 4 cycles later) -> Mem_Req held until ack; no CDB_Req; no further accept until IDLE.
- Flush in the same cycle as CDB_Grant -> no broadcast is counted; CDB_Req is 0 next cycle; IDLE.
- Misaligned load to 0x102:
  - With LS_ALIGN_CHECK_EN, LS_Exception pulses with the tag and Mem_Req stays 0.
  - Without it, Mem_Addr is 0x100.
